// File: rtl/rc_sched_pkg.sv
// Shared types and helpers for the recompute scheduler.
// The recompute width defines fall back to local defaults when the shared header is absent.
`ifndef RECOMPUTE_SCALE_WIDTH
`define RECOMPUTE_SCALE_WIDTH 16
`endif
`ifndef RECOMPUTE_SHIFT_WIDTH
`define RECOMPUTE_SHIFT_WIDTH 5
`endif

package rc_sched_pkg;

    localparam int unsigned RcScaleW = `RECOMPUTE_SCALE_WIDTH;
    localparam int unsigned RcShiftW = `RECOMPUTE_SHIFT_WIDTH;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStream,
        StDrain,
        StClear
    } rc_sched_state_t;

    // Requester index width; a single requester still gets a 1-bit id.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rc_sched_if.sv
// Requester, recompute-unit and response signals of the scheduler.
// master = the scheduler itself, slave = requesters plus recompute unit.
interface rc_sched_if
    import rc_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned IN_DATA_WIDTH  = 24,
    parameter int unsigned OUT_DATA_WIDTH = 24,
    parameter int unsigned SCALE_W        = `RECOMPUTE_SCALE_WIDTH,
    parameter int unsigned SHIFT_W        = `RECOMPUTE_SHIFT_WIDTH,
    parameter int unsigned ID_W           = id_width(NUM_REQ)
) ();

    logic [NUM_REQ-1:0]                     req_vld;
    logic [NUM_REQ-1:0][IN_DATA_WIDTH-1:0]  req_data;
    logic [NUM_REQ-1:0]                     req_last;
    logic [NUM_REQ-1:0]                     req_rdy;
    logic [NUM_REQ-1:0][SCALE_W-1:0]        req_scale;
    logic [NUM_REQ-1:0][SHIFT_W-1:0]        req_shift;
    logic [NUM_REQ-1:0]                     req_rc_needed;

    logic [SCALE_W-1:0]                     rc_scale;
    logic                                   rc_scale_vld;
    logic                                   rc_scale_clear;
    logic [SHIFT_W-1:0]                     rc_shift;
    logic                                   rc_recompute_needed;
    logic [IN_DATA_WIDTH-1:0]               rc_in_data;
    logic                                   rc_in_data_vld;
    logic [OUT_DATA_WIDTH-1:0]              rc_out_data;
    logic                                   rc_out_data_vld;
    logic                                   rc_error;

    logic [OUT_DATA_WIDTH-1:0]              rsp_data;
    logic                                   rsp_vld;
    logic [ID_W-1:0]                        rsp_id;
    logic                                   err;

    modport master (
        input  req_vld, req_data, req_last, req_scale, req_shift, req_rc_needed,
        input  rc_out_data, rc_out_data_vld, rc_error,
        output req_rdy,
        output rc_scale, rc_scale_vld, rc_scale_clear, rc_shift, rc_recompute_needed,
        output rc_in_data, rc_in_data_vld,
        output rsp_data, rsp_vld, rsp_id, err
    );

    modport slave (
        output req_vld, req_data, req_last, req_scale, req_shift, req_rc_needed,
        output rc_out_data, rc_out_data_vld, rc_error,
        input  req_rdy,
        input  rc_scale, rc_scale_vld, rc_scale_clear, rc_shift, rc_recompute_needed,
        input  rc_in_data, rc_in_data_vld,
        input  rsp_data, rsp_vld, rsp_id, err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above last_i, wrapping around.
// Produces a one-hot grant plus the matching index; no state of its own.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);

    always_comb begin
        logic            found;
        int unsigned     cand;
        logic [ID_W-1:0] cidx;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        cidx  = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(last_i) + off) % NUM_REQ;
            cidx = ID_W'(cand);
            if (!found && req_i[cidx]) begin
                found       = 1'b1;
                gnt_o[cidx] = 1'b1;
                idx_o       = cidx;
            end
        end
    end

endmodule

// File: rtl/rc_sched.sv
// Burst scheduler in front of a shared recompute unit: grants one requester at a time,
// loads its scale/shift, streams beats under an outstanding-credit limit, drains, clears.
module rc_sched
    import rc_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned IN_DATA_WIDTH   = 24,
    parameter int unsigned OUT_DATA_WIDTH  = 24,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned SCALE_W         = `RECOMPUTE_SCALE_WIDTH,
    parameter int unsigned SHIFT_W         = `RECOMPUTE_SHIFT_WIDTH
) (
    input logic         clk,
    input logic         rst_n,
    rc_sched_if.master  bus
);

    localparam int unsigned ID_W  = id_width(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    rc_sched_state_t    state_q;
    logic [ID_W-1:0]    last_grant_q;
    logic [ID_W-1:0]    grant_id_q;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic               err_q, err_d;
    logic [SCALE_W-1:0] rc_scale_q;
    logic [SHIFT_W-1:0] rc_shift_q;
    logic               rc_rc_needed_q;
    logic               rc_scale_vld_q;
    logic               rc_scale_clear_q;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic [NUM_REQ-1:0] rdy;
    logic               slot_free;
    logic               beat_acc;
    logic               underflow;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i  (bus.req_vld),
        .last_i (last_grant_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    assign arb_any = |arb_gnt;

    // Only the granted requester sees ready, and only while a credit is free.
    always_comb begin
        slot_free = (outstanding_q < CNT_W'(MAX_OUTSTANDING));
        rdy       = '0;
        if (state_q == StStream) begin
            rdy[grant_id_q] = slot_free;
        end
        beat_acc = rdy[grant_id_q] & bus.req_vld[grant_id_q];
    end

    // A response with nothing in flight is an underflow: flag it, keep the counter at 0.
    always_comb begin
        outstanding_d = outstanding_q;
        underflow     = bus.rc_out_data_vld && (outstanding_q == '0);
        if (beat_acc && !bus.rc_out_data_vld) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!beat_acc && bus.rc_out_data_vld && !underflow) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end
        err_d = err_q | bus.rc_error | underflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            last_grant_q     <= ID_W'(NUM_REQ - 1);
            grant_id_q       <= '0;
            outstanding_q    <= '0;
            err_q            <= 1'b0;
            rc_scale_q       <= '0;
            rc_shift_q       <= '0;
            rc_rc_needed_q   <= 1'b0;
            rc_scale_vld_q   <= 1'b0;
            rc_scale_clear_q <= 1'b0;
        end else begin
            outstanding_q    <= outstanding_d;
            err_q            <= err_d;
            rc_scale_vld_q   <= 1'b0;
            rc_scale_clear_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (arb_any) begin
                        grant_id_q     <= arb_idx;
                        last_grant_q   <= arb_idx;
                        rc_scale_q     <= bus.req_scale[arb_idx];
                        rc_shift_q     <= bus.req_shift[arb_idx];
                        rc_rc_needed_q <= bus.req_rc_needed[arb_idx];
                        rc_scale_vld_q <= 1'b1;
                        state_q        <= StLoad;
                    end
                end
                StLoad: begin
                    state_q <= StStream;
                end
                StStream: begin
                    // A stalled requester simply leaves us here; there is no time-out.
                    if (beat_acc && bus.req_last[grant_id_q]) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (outstanding_q == '0) begin
                        rc_scale_clear_q <= 1'b1;
                        state_q          <= StClear;
                    end
                end
                StClear: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req_rdy             = rdy;
    assign bus.rc_scale            = rc_scale_q;
    assign bus.rc_shift            = rc_shift_q;
    assign bus.rc_recompute_needed = rc_rc_needed_q;
    assign bus.rc_scale_vld        = rc_scale_vld_q;
    assign bus.rc_scale_clear      = rc_scale_clear_q;
    assign bus.rc_in_data          = bus.req_data[grant_id_q];
    assign bus.rc_in_data_vld      = beat_acc;
    assign bus.rsp_data            = bus.rc_out_data;
    assign bus.rsp_vld             = bus.rc_out_data_vld;
    assign bus.rsp_id              = grant_id_q;
    assign bus.err                 = err_q;

endmodule
